lcd_cmd_driver: RTL and testbench
=================================

# lcd_cmd_driver

Sequenced driver for the character LCD (HD44780-compatible) behind the LSU's LCD output register at 0x2A0. Each store to that address pushes one command/data byte into a 4-entry FIFO. An FSM pops entries and drives the LCD pins with the required setup, enable-pulse, hold and execution-delay timing. Busy and overflow status are exported so software, through the switch/status region, can pace its writes.

## Interface
Parameters:
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises.
- PULSE_CYC, 12: cycles EN is held high.
- HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- EXEC_CYC, 2000: execution wait for normal commands/data (40 µs at 50 MHz).
- LONG_CYC, 82000: execution wait for clear (0x01) and home (0x02/0x03) when RS=0.
- Counter width: $clog2 of the largest of the five parameters, plus 1.

Ports:
- clk_i, in, 1: system clock, rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- lcd_we_i, in, 1: store strobe for address 0x2A0 (st_en && addr==0x2A0).
- lcd_wdata_i, in, 32: store data. [31]=LCD_ON, [9]=RS, [7:0]=byte. Other bits ignored.
- lcd_on_o, out, 1: LCD power/backlight enable.
- lcd_rs_o, out, 1: register select.
- lcd_rw_o, out, 1: tied 0 (write only).
- lcd_en_o, out, 1: enable strobe.
- lcd_data_o, out, 8: data bus.
- busy_o, out, 1: FSM not IDLE or FIFO not empty.
- full_o, out, 1: FIFO holds 4 entries.
- overflow_o, out, 1: sticky. Set when a write is dropped.
- level_o, out, 3: FIFO occupancy, 0..4.

## Operation
- FIFO: 4 entries × 10 bits {ON, RS, byte}, with 2-bit read/write pointers that wrap 3→0 and a 3-bit count.
- Push: on lcd_we_i=1 with registered count<4, write the entry and increment the write pointer.
- Push while full: entry is dropped, pointers are unchanged, overflow_o←1. overflow_o is cleared only by rst_i.
- Pop: occurs only on the IDLE→SETUP transition. Push and pop in the same cycle leave count unchanged, and both succeed if count<4.
- "Full" is judged on the registered count before that cycle's pop. A write in the pop cycle with count==4 is dropped.
- FSM states are IDLE, SETUP, PULSE, HOLD, WAIT.
  - IDLE: if count>0, pop, latch the entry into the output registers, load the counter with SETUP_CYC−1 and go to SETUP.
  - SETUP: EN=0. When counter==0, load PULSE_CYC−1 and go to PULSE.
  - PULSE: EN=1. When counter==0, load HOLD_CYC−1 and go to HOLD.
  - HOLD: EN=0, RS/DATA held. When counter==0, load the wait length −1 and go to WAIT.
  - WAIT: EN=0. When counter==0, go to IDLE.
- Wait length is LONG_CYC if RS=0 and byte∈{0x01,0x02,0x03}, otherwise EXEC_CYC.
- The counter decrements by 1 in every non-IDLE state.
- lcd_on_o, lcd_rs_o and lcd_data_o change only at a pop and hold their values through IDLE until the next pop.
- Reset values: lcd_on_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_en_o=0, lcd_data_o=0x00, busy_o=0, full_o=0, overflow_o=0, level_o=0. Reset also sets FSM=IDLE, pointers=0 and counter=0.
- Reset mid-transfer: on the next edge, EN drops to 0, all queued entries are discarded and the FSM returns to IDLE. No partial pulse completes.

## Timing
- All outputs are registered and there is no combinational path from inputs to outputs.
- Write sampled at edge N: level_o updates after edge N.
- If the FIFO was empty and the FSM was IDLE:
  - the pop occurs at edge N+1 and the new RS/DATA appear after N+1;
  - EN rises after edge N+1+SETUP_CYC;
  - EN is high for exactly PULSE_CYC cycles.
- Per-entry occupancy of the bus: SETUP+PULSE+HOLD+wait cycles, plus 1 IDLE cycle before the next pop.
- Back-to-back entries are separated by exactly one IDLE cycle.
- busy_o rises the cycle after the write edge. It falls the cycle after WAIT expires with the FIFO empty.

## Test plan
Bench parameters: SETUP=1, PULSE=2, HOLD=1, EXEC=4, LONG=8.
- Single write 0x8000_0241 (ON=1, RS=1, byte=0x41) at edge 0 -> outputs ON=1/RS=1/DATA=0x41 after edge 1; EN high after edges 2–3; busy_o drops after edge 9.
- Write 0x0000_0001 (clear) -> WAIT lasts 8 cycles, and EN pulse width is 2.
- Five back-to-back writes while IDLE, bytes 0x10..0x14 -> first pops, next 4 fill the FIFO, none dropped, overflow_o=0. Six writes -> the 6th is dropped, overflow_o=1, and EN pulses carry 0x10..0x14 in order.
- Write in the same cycle as a pop with level_o=4 -> dropped. Write with level_o=3 during a pop -> accepted, and level_o stays 3.
- Assert rst_i while lcd_en_o=1 with 2 entries queued -> next cycle EN=0, level_o=0, busy_o=0, DATA=0x00, overflow_o=0, and no further pulses.
- Eight writes with pointer wrap across two fill/drain rounds -> output byte order matches write order exactly.

Source files
------------

// File: rtl/lcd_cmd_driver.sv
// lcd_cmd_driver: 4-entry {ON, RS, byte} command FIFO feeding an HD44780 write sequencer.
// The FSM paces setup, enable pulse, hold and execution wait for every popped entry.
module lcd_cmd_driver #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 2,
  parameter int EXEC_CYC  = 2000,
  parameter int LONG_CYC  = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lcd_we_i,
  input  logic [31:0] lcd_wdata_i,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o,
  output logic        busy_o,
  output logic        full_o,
  output logic        overflow_o,
  output logic [2:0]  level_o
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_SPH = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int MAX_EL  = (EXEC_CYC > LONG_CYC) ? EXEC_CYC : LONG_CYC;
  localparam int MAX_CYC = (MAX_SPH > MAX_EL) ? MAX_SPH : MAX_EL;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] L_PULSE = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] L_EXEC  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] L_LONG  = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] L_ONE   = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_en;
  logic          r_on;
  logic          r_rs;
  logic [7:0]    r_data;

  logic [9:0]    r_mem [4];
  logic [1:0]    r_wptr;
  logic [1:0]    r_rptr;
  logic [2:0]    r_count;
  logic          r_ovf;
  logic          r_full;
  logic          r_busy;

  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [2:0]    w_count_next;
  logic          w_fsm_active_next;
  logic          w_long;
  logic [9:0]    w_head;
  logic [9:0]    w_entry;
  logic          w_unused_bits;

  assign w_entry       = {lcd_wdata_i[31], lcd_wdata_i[9], lcd_wdata_i[7:0]};
  assign w_unused_bits = ^{lcd_wdata_i[30:10], lcd_wdata_i[8]};
  assign w_head        = r_mem[r_rptr];

  // Full is judged on the registered count, so a write in a pop cycle at count 4 is dropped.
  assign w_pop  = (r_state == ST_IDLE) && (r_count != 3'd0);
  assign w_push = lcd_we_i && (r_count < 3'd4);
  assign w_drop = lcd_we_i && (r_count >= 3'd4);

  // Clear and home need the long execution wait; everything else uses the normal one.
  assign w_long = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02) || (r_data == 8'h03));

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 3'd1;
      2'b01:   w_count_next = r_count - 3'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_fsm_active_next = 1'b1;
    case (r_state)
      ST_IDLE: w_fsm_active_next = w_pop;
      ST_WAIT: w_fsm_active_next = (r_cnt != '0);
      default: w_fsm_active_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
      r_ovf   <= 1'b0;
      r_full  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == 3'd4);
      r_busy  <= w_fsm_active_next || (w_count_next != 3'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_on    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            {r_on, r_rs, r_data} <= w_head;
            r_cnt   <= L_SETUP;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_cnt   <= L_PULSE;
            r_en    <= 1'b1;
            r_state <= ST_PULSE;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_cnt   <= L_HOLD;
            r_en    <= 1'b0;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_cnt   <= w_long ? L_LONG : L_EXEC;
            r_state <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign lcd_on_o   = r_on;
  assign lcd_rs_o   = r_rs;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = r_en;
  assign lcd_data_o = r_data;
  assign busy_o     = r_busy;
  assign full_o     = r_full;
  assign overflow_o = r_ovf;
  assign level_o    = r_count;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Bench for lcd_cmd_driver: a queue plus "cycles since pop" model predicts every output each cycle.
module tb_lcd_cmd_driver;
  localparam int SETUP = 1;
  localparam int PULSE = 2;
  localparam int HOLD  = 1;
  localparam int EXEC  = 4;
  localparam int LONG  = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lcd_we_i;
  logic [31:0] lcd_wdata_i;
  logic        lcd_on_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic [7:0]  lcd_data_o;
  logic        busy_o;
  logic        full_o;
  logic        overflow_o;
  logic [2:0]  level_o;

  lcd_cmd_driver #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
    .EXEC_CYC(EXEC), .LONG_CYC(LONG)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lcd_we_i(lcd_we_i), .lcd_wdata_i(lcd_wdata_i),
    .lcd_on_o(lcd_on_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_en_o(lcd_en_o),
    .lcd_data_o(lcd_data_o), .busy_o(busy_o), .full_o(full_o), .overflow_o(overflow_o),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Model: pending entries, the entry on the bus, and cycles elapsed since its pop (-1 = idle).
  logic [9:0] m_q[$];
  logic [9:0] m_cur = '0;
  int         m_t   = -1;
  int         m_dur = 0;
  int         m_sz  = 0;
  logic       m_ovf = 1'b0;
  logic [9:0] exp_pulses[$];
  logic [9:0] obs_pulses[$];
  logic       prev_en = 1'b0;

  function automatic bit is_long(input logic [9:0] e);
    return !e[8] && (e[7:0] >= 8'd1) && (e[7:0] <= 8'd3);
  endfunction

  function automatic logic [17:0] exp_vec();
    logic en;
    logic busy;
    en   = (m_t >= SETUP) && (m_t < SETUP + PULSE);
    busy = (m_t >= 0) || (m_q.size() > 0);
    return {m_cur[9], m_cur[8], 1'b0, en, m_cur[7:0], busy, (m_q.size() == 4), m_ovf, 3'(m_q.size())};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o, busy_o, full_o, overflow_o, level_o};
  endfunction

  task automatic model_update();
    if (rst_i) begin
      m_q.delete();
      m_cur = '0;
      m_t   = -1;
      m_dur = 0;
      m_ovf = 1'b0;
    end else begin
      m_sz = m_q.size();
      if (m_t < 0 && m_sz > 0) begin
        m_cur = m_q.pop_front();
        m_t   = 0;
        m_dur = SETUP + PULSE + HOLD + (is_long(m_cur) ? LONG : EXEC);
      end else if (m_t >= 0) begin
        m_t++;
        if (m_t == m_dur) m_t = -1;
      end
      if (lcd_we_i) begin
        if (m_sz < 4) m_q.push_back({lcd_wdata_i[31], lcd_wdata_i[9], lcd_wdata_i[7:0]});
        else m_ovf = 1'b1;
        $display("txn t=%0t write %h %s", $time, lcd_wdata_i, (m_sz < 4) ? "queued" : "dropped");
      end
      if (m_t == SETUP) exp_pulses.push_back(m_cur);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (lcd_en_o && !prev_en) obs_pulses.push_back({lcd_on_o, lcd_rs_o, lcd_data_o});
    prev_en <= lcd_en_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_i = 1'b1; lcd_we_i = 1'b0; lcd_wdata_i = '0;
    tick(); tick();
    n_cmp++;
    if (obs_vec() !== 18'h0) begin
      n_err++; $display("FAIL reset_values obs=%h exp=%h", obs_vec(), 18'h0);
    end
    rst_i = 1'b0;
    tick();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_idle obs=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    lcd_we_i = 1'b1; lcd_wdata_i = 32'h8000_0241;
    tick();
    lcd_we_i = 1'b0;
    n_cmp++;
    if ({busy_o, level_o} !== {1'b1, 3'd1}) begin
      n_err++; $display("FAIL single_after_write busy/level obs=%b/%0d exp=1/1", busy_o, level_o);
    end
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL single_model cyc=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        n_cmp++;
        if ({lcd_on_o, lcd_rs_o, lcd_en_o, lcd_data_o} !== {1'b1, 1'b1, 1'b0, 8'h41}) begin
          n_err++; $display("FAIL single_pop on/rs/en/data obs=%b/%b/%b/%h exp=1/1/0/41",
                            lcd_on_o, lcd_rs_o, lcd_en_o, lcd_data_o);
        end
      end
      if (c >= 2 && c <= 4) begin
        n_cmp++;
        if (lcd_en_o !== (c != 4)) begin
          n_err++; $display("FAIL single_en cyc=%0d obs=%b exp=%b", c, lcd_en_o, (c != 4));
        end
      end
      if (c == 8 || c == 9) begin
        n_cmp++;
        if (busy_o !== (c == 8)) begin
          n_err++; $display("FAIL single_busy cyc=%0d obs=%b exp=%b", c, busy_o, (c == 8));
        end
      end
    end
  endtask

  task automatic test_clear();
    int en_w = 0;
    int post_en = 0;
    int busy_c = 1;
    bit done = 0;
    lcd_we_i = 1'b1; lcd_wdata_i = 32'h0000_0001;
    tick();
    lcd_we_i = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL clear_model cyc=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (lcd_en_o) en_w++;
      else if (en_w > 0 && busy_o) post_en++;
      if (busy_o) busy_c++;
      else done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL clear_timeout busy still high after 40 cycles");
    end
    n_cmp++;
    if (en_w != PULSE) begin
      n_err++; $display("FAIL clear_pulse_width obs=%0d exp=%0d", en_w, PULSE);
    end
    n_cmp++;
    if (post_en - HOLD != LONG) begin
      n_err++; $display("FAIL clear_wait_len obs=%0d exp=%0d", post_en - HOLD, LONG);
    end
    n_cmp++;
    if (busy_c != 1 + SETUP + PULSE + HOLD + LONG) begin
      n_err++; $display("FAIL clear_busy_len obs=%0d exp=%0d", busy_c, 1 + SETUP + PULSE + HOLD + LONG);
    end
  endtask

  task automatic test_overflow();
    bit done = 0;
    obs_pulses.delete();
    for (int i = 0; i < 6; i++) begin
      lcd_we_i = 1'b1; lcd_wdata_i = 32'h0000_0210 + 32'(i);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ovf_model wr=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (i >= 4) begin
        n_cmp++;
        if ({level_o, full_o, overflow_o} !== {3'd4, 1'b1, (i == 5)}) begin
          n_err++; $display("FAIL ovf_status wr=%0d level/full/ovf obs=%0d/%b/%b exp=4/1/%b",
                            i, level_o, full_o, overflow_o, (i == 5));
        end
      end
    end
    lcd_we_i = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL ovf_drain cyc=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (!busy_o) done = 1;
    end
    n_cmp++;
    if (!done || obs_pulses.size() != 5) begin
      n_err++; $display("FAIL ovf_pulse_count obs=%0d exp=5 drained=%b", obs_pulses.size(), done);
    end
    for (int i = 0; i < obs_pulses.size() && i < 5; i++) begin
      n_cmp++;
      if (obs_pulses[i] !== {2'b01, 8'h10 + 8'(i)}) begin
        n_err++; $display("FAIL ovf_pulse_order idx=%0d obs=%h exp=%h", i, obs_pulses[i], {2'b01, 8'h10 + 8'(i)});
      end
    end
  endtask

  task automatic test_pop_collision();
    logic [9:0] sent[$];
    bit ready;
    bit done;
    for (int pass = 0; pass < 2; pass++) begin
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      sent.delete(); obs_pulses.delete();
      // pass 0 fills to 4 before the pop edge, pass 1 only to 3
      for (int i = 0; i < 5 - pass; i++) begin
        lcd_we_i = 1'b1; lcd_wdata_i = 32'h0000_0220 + 32'(16 * pass + i);
        sent.push_back({2'b01, lcd_wdata_i[7:0]});
        tick();
      end
      lcd_we_i = 1'b0;
      ready = 0;
      for (int c = 0; c < 50 && !ready; c++) begin
        if (m_t < 0 && m_q.size() > 0) ready = 1;
        else tick();
      end
      n_cmp++;
      if (!ready) begin
        n_err++; $display("FAIL collide_timeout pass=%0d no pre-pop cycle seen", pass);
      end
      lcd_we_i = 1'b1; lcd_wdata_i = 32'h0000_02F0 + 32'(pass);
      if (pass == 1) sent.push_back({2'b01, lcd_wdata_i[7:0]});
      tick();
      lcd_we_i = 1'b0;
      n_cmp++;
      if ({level_o, overflow_o} !== {3'd3, (pass == 0)}) begin
        n_err++; $display("FAIL collide_status pass=%0d level/ovf obs=%0d/%b exp=3/%b",
                          pass, level_o, overflow_o, (pass == 0));
      end
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_err++; $display("FAIL collide_model pass=%0d cyc=%0d obs=%h exp=%h", pass, c, obs_vec(), exp_vec());
        end
        if (!busy_o) done = 1;
      end
      n_cmp++;
      if (obs_pulses.size() != sent.size()) begin
        n_err++; $display("FAIL collide_pulse_count pass=%0d obs=%0d exp=%0d", pass, obs_pulses.size(), sent.size());
      end
      for (int i = 0; i < obs_pulses.size() && i < sent.size(); i++) begin
        n_cmp++;
        if (obs_pulses[i] !== sent[i]) begin
          n_err++; $display("FAIL collide_order pass=%0d idx=%0d obs=%h exp=%h", pass, i, obs_pulses[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lcd_we_i = 1'b1; lcd_wdata_i = 32'h8000_0251 + 32'(i);
      tick();
    end
    lcd_we_i = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (lcd_en_o) seen = 1;
      else tick();
    end
    n_cmp++;
    if (!seen || level_o !== 3'd2) begin
      n_err++; $display("FAIL rstmid_setup en_seen=%b level obs=%0d exp=2", seen, level_o);
    end
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    n_cmp++;
    if (obs_vec() !== 18'h0) begin
      n_err++; $display("FAIL rstmid_cleared obs=%h exp=%h", obs_vec(), 18'h0);
    end
    obs_pulses.delete();
    for (int c = 0; c < 30; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rstmid_model cyc=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (obs_pulses.size() != 0) begin
      n_err++; $display("FAIL rstmid_no_pulse obs=%0d exp=0", obs_pulses.size());
    end
  endtask

  task automatic test_wrap();
    logic [9:0] sent[$];
    bit done;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    obs_pulses.delete();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        lcd_we_i = 1'b1; lcd_wdata_i = $urandom;
        sent.push_back({lcd_wdata_i[31], lcd_wdata_i[9], lcd_wdata_i[7:0]});
        tick();
      end
      lcd_we_i = 1'b0;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_err++; $display("FAIL wrap_model round=%0d cyc=%0d obs=%h exp=%h", r, c, obs_vec(), exp_vec());
        end
        if (!busy_o) done = 1;
      end
    end
    n_cmp++;
    if (obs_pulses.size() != 8) begin
      n_err++; $display("FAIL wrap_pulse_count obs=%0d exp=8", obs_pulses.size());
    end
    for (int i = 0; i < obs_pulses.size() && i < 8; i++) begin
      n_cmp++;
      if (obs_pulses[i] !== sent[i]) begin
        n_err++; $display("FAIL wrap_order idx=%0d obs=%h exp=%h", i, obs_pulses[i], sent[i]);
      end
    end
  endtask

  task automatic test_random();
    bit done = 0;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    obs_pulses.delete(); exp_pulses.delete();
    for (int c = 0; c < 600; c++) begin
      rst_i       = ($urandom_range(0, 199) == 0);
      lcd_we_i    = ($urandom_range(0, 3) == 0);
      lcd_wdata_i = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        lcd_wdata_i[9]   = 1'b0;
        lcd_wdata_i[7:0] = 8'($urandom_range(1, 3));
      end
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_model cyc=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    rst_i = 1'b0; lcd_we_i = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_drain cyc=%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (!busy_o) done = 1;
    end
    n_cmp++;
    if (obs_pulses.size() != exp_pulses.size()) begin
      n_err++; $display("FAIL random_pulse_count obs=%0d exp=%0d", obs_pulses.size(), exp_pulses.size());
    end
    for (int i = 0; i < obs_pulses.size() && i < exp_pulses.size(); i++) begin
      n_cmp++;
      if (obs_pulses[i] !== exp_pulses[i]) begin
        n_err++; $display("FAIL random_order idx=%0d obs=%h exp=%h", i, obs_pulses[i], exp_pulses[i]);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; lcd_we_i = 1'b0; lcd_wdata_i = '0;
    test_reset();
    test_single();
    test_clear();
    test_overflow();
    test_pop_collision();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
